rom_ctrl_scan_reader: RTL
=========================

ROM_CTRL_SCAN_READER -- requirements
Module: rom_ctrl_scan_reader

Interface
REQ-001 SHALL have parameter AW, default 8, meaning ROM word address width.
REQ-002 SHALL have parameter DW, default 39, meaning ROM word width including ECC.
REQ-003 SHALL have parameter RomDepth, default 256, meaning words scanned; legal range 2..2**AW, elaboration error otherwise.
REQ-004 SHALL have clk_i input 1 (clock); reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-005 SHALL have start_i input 1, a pulse that begins the scan.
REQ-006 SHALL have chk_req_o output 1 (ROM read request) and chk_addr_o output AW (read address toward the mux).
REQ-007 SHALL have chk_rdata_i input DW, the scrambled read data valid exactly one cycle after chk_req_o.
REQ-008 SHALL have data_o output DW, data_valid_o output 1, data_ready_i input 1 and data_last_o output 1, forming the word stream to the digest engine.
REQ-009 SHALL have sel_bus_o output 4 (mubi4_t), the mux select that grants the bus.
REQ-010 SHALL have done_o output 1 and alert_o output 1 (fatal fault).

Function
REQ-011 SHALL implement states Idle, Reading, Draining, Done and Invalid.
- Idle->Reading on start_i.
- Reading->Draining once request RomDepth-1 is issued.
- Draining->Done once the last word is popped.
- Any->Invalid on fault.
REQ-012 SHALL ignore start_i outside Idle.
REQ-013 SHALL issue addresses 0..RomDepth-1 in order, one per request, with no wrap and no repeat.
REQ-014 SHALL assert chk_req_o only in Reading, and only when fifo_count + outstanding - pop < 2, where outstanding is 1 if a request was made in the previous cycle.
REQ-015 SHALL push chk_rdata_i into a 2-entry FIFO in the cycle after each request, together with a last flag set for address RomDepth-1.
REQ-016 SHALL drive data_o, data_valid_o and data_last_o from the FIFO head; a word pops when data_valid_o and data_ready_i are both high.
REQ-017 SHALL sustain one word per cycle while data_ready_i stays high.
REQ-018 SHALL hold data_o stable while data_valid_o is high and data_ready_i is low.
REQ-019 SHALL accept a push and a pop in the same cycle, leaving the count unchanged.
REQ-020 SHALL, in the cycle after the last pop, enter Done and set sel_bus_o to MuBi4True and done_o to 1.
REQ-021 SHALL keep sel_bus_o True until reset, including after any later fault; sel_bus_o never returns from True to False.
REQ-022 SHALL detect these faults:
- state register holding a non-legal encoding;
- FIFO push while full;
- FIFO pop while empty.
REQ-023 SHALL, on a fault, enter Invalid, drop chk_req_o and data_valid_o, and set alert_o from the next cycle, sticky until reset.
REQ-024 SHALL drive sel_bus_o as MuBi4False in every state that has not yet reached Done.

Reset
REQ-025 SHALL, while rst_ni is low, drive all outputs to these values:
- chk_req_o=0, chk_addr_o=0;
- data_valid_o=0, data_last_o=0, data_o=0;
- sel_bus_o=MuBi4False;
- done_o=0, alert_o=0;
- state=Idle, FIFO empty.
REQ-026 SHALL, if reset asserts mid-scan, abandon the scan immediately with no residual outstanding request or FIFO content after release.

Configuration
REQ-027 SHALL, with ROM_CTRL_SCAN_CNT_CHECK_EN defined, keep a second independent address counter and compare it with the primary counter every cycle, treating any mismatch as a fault per REQ-023.
REQ-028 SHALL, with ROM_CTRL_SCAN_CNT_CHECK_EN undefined, omit the duplicate counter and comparator; all other behaviour is identical.

Structure
REQ-029 SHALL place in rom_ctrl_pkg the state enum (sparse encoding, pairwise Hamming distance at least 3) and its width constant.
REQ-030 SHALL build the FIFO from one prim_fifo_sync instance (Depth 2, Width DW+1), with its full/empty error outputs feeding the fault detection.
REQ-031 SHALL build the state register from prim_sparse_fsm_flop.

Verification
REQ-032 Full scan: RomDepth=4, data_ready_i=1, start_i pulse -> chk_addr_o 0,1,2,3 on consecutive cycles; 4 words out back-to-back; data_last_o high on the 4th word only; sel_bus_o=MuBi4True one cycle after the last pop.
REQ-033 Backpressure: data_ready_i=0 after the first word -> at most 2 requests outstanding in FIFO plus flight, chk_req_o low, data_o stable; on release, all remaining words arrive in order with no loss or duplication.
REQ-034 Late start: start_i asserted in Reading and in Done -> no change in state or address sequence.
REQ-035 Fault: force the state register to a non-legal encoding during Reading -> chk_req_o=0 next cycle, alert_o=1 held, sel_bus_o=MuBi4False; repeat after Done -> sel_bus_o stays MuBi4True while alert_o=1.
REQ-036 Reset mid-scan: rst_ni low at address 2 -> all outputs take reset values immediately; a new start_i scans from address 0.
REQ-037 With ROM_CTRL_SCAN_CNT_CHECK_EN defined, flip one bit of the primary counter -> alert_o=1 within 2 cycles.

Source files
------------

// File: rtl/rom_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rom_ctrl_pkg : shared types for the ROM controller scan reader
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
package rom_ctrl_pkg;

   typedef logic [3:0] mubi4_t;
   localparam mubi4_t MuBi4True  = 4'h6;
   localparam mubi4_t MuBi4False = 4'h9;

   localparam int unsigned ScanStateWidth = 6;

   // Every pair of codes differs in at least three bits.
   typedef enum logic [ScanStateWidth-1:0] {
      ScanIdle     = 6'b000111,
      ScanReading  = 6'b011001,
      ScanDraining = 6'b101010,
      ScanDone     = 6'b110100,
      ScanInvalid  = 6'b111111
   } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/prim_fifo_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prim_fifo_sync : small synchronous FIFO with push-full / pop-empty errors
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module prim_fifo_sync #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wvalid_i,
   input  logic [Width-1:0]           wdata_i,
   input  logic                       rready_i,
   output logic                       rvalid_o,
   output logic [Width-1:0]           rdata_o,
   output logic [$clog2(Depth+1)-1:0] depth_o,
   output logic                       err_full_o,
   output logic                       err_empty_o
);

   localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned DepthW = $clog2(Depth + 1);

   logic [Width-1:0]  mem_q [Depth];
   logic [Width-1:0]  mem_d [Depth];
   logic [PtrW-1:0]   wptr_q, wptr_d;
   logic [PtrW-1:0]   rptr_q, rptr_d;
   logic [DepthW-1:0] cnt_q, cnt_d;
   logic              full, empty, do_push, do_pop;

   assign full    = (cnt_q == DepthW'(Depth));
   assign empty   = (cnt_q == '0);
   assign do_push = wvalid_i & ~full;
   assign do_pop  = rready_i & ~empty;

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) begin
         mem_d[wptr_q] = wdata_i;
         wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + DepthW'(1);
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - DepthW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign rvalid_o    = ~empty;
   assign rdata_o     = mem_q[rptr_q];
   assign depth_o     = cnt_q;
   assign err_full_o  = wvalid_i & full;
   assign err_empty_o = rready_i & empty;

endmodule
`default_nettype wire

// File: rtl/prim_sparse_fsm_flop.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prim_sparse_fsm_flop : state register for sparsely encoded FSMs
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module prim_sparse_fsm_flop #(
   parameter int unsigned           Width      = 1,
   parameter logic [Width-1:0]      ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] state_i,
   output logic [Width-1:0] state_o
);

   logic [Width-1:0] state_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ResetValue;
      end else begin
         state_q <= state_i;
      end
   end

   assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/rom_ctrl_scan_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rom_ctrl_scan_reader : streams every ROM word to the digest engine, then
// hands the bus over.  Option: ROM_CTRL_SCAN_CNT_CHECK_EN adds a shadow counter.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module rom_ctrl_scan_reader
   import rom_ctrl_pkg::*;
#(
   parameter int unsigned AW       = 8,
   parameter int unsigned DW       = 39,
   parameter int unsigned RomDepth = 256
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   output logic          chk_req_o,
   output logic [AW-1:0] chk_addr_o,
   input  logic [DW-1:0] chk_rdata_i,
   output logic [DW-1:0] data_o,
   output logic          data_valid_o,
   input  logic          data_ready_i,
   output logic          data_last_o,
   output mubi4_t        sel_bus_o,
   output logic          done_o,
   output logic          alert_o
);

   if ((RomDepth < 2) || (64'(RomDepth) > (64'd1 << AW))) begin : g_rom_depth_check
      $error("RomDepth must lie in 2..2**AW");
   end

   localparam logic [AW-1:0] LastAddr = AW'(RomDepth - 1);

   scan_state_e               state_q, state_d;
   logic [ScanStateWidth-1:0] state_raw;

   logic [AW-1:0] addr_q, addr_d;
   logic          req_q, req_d;
   logic          last_q, last_d;
   logic          alert_q, alert_d;
   mubi4_t        sel_bus_q, sel_bus_d;

   logic          chk_req, credit_ok, state_illegal, fault, cnt_mismatch;
   logic          scan_active;
   logic          fifo_pop, fifo_rvalid, fifo_err_full, fifo_err_empty;
   logic [DW:0]   fifo_rdata;
   logic [1:0]    fifo_depth;

   prim_sparse_fsm_flop #(
      .Width      (ScanStateWidth),
      .ResetValue (ScanIdle)
   ) u_state_regs (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .state_i (state_d),
      .state_o (state_raw)
   );

   assign state_q = scan_state_e'(state_raw);

   // Bit DW of each entry marks the word read from the final address.
   prim_fifo_sync #(
      .Width (DW + 1),
      .Depth (2)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .wvalid_i    (req_q),
      .wdata_i     ({last_q, chk_rdata_i}),
      .rready_i    (fifo_pop),
      .rvalid_o    (fifo_rvalid),
      .rdata_o     (fifo_rdata),
      .depth_o     (fifo_depth),
      .err_full_o  (fifo_err_full),
      .err_empty_o (fifo_err_empty)
   );

   assign scan_active  = (state_q == ScanReading) || (state_q == ScanDraining);
   assign data_valid_o = fifo_rvalid & scan_active;
   assign fifo_pop     = data_valid_o & data_ready_i;

   always_comb begin
      state_d       = state_q;
      chk_req       = 1'b0;
      state_illegal = 1'b0;
      // Occupied slots plus the word in flight must leave room for one more.
      credit_ok     = ({1'b0, fifo_depth} + {2'b00, req_q}) < (3'd2 + {2'b00, fifo_pop});
      case (state_q)
         ScanIdle: begin
            if (start_i) begin
               state_d = ScanReading;
            end
         end
         ScanReading: begin
            chk_req = credit_ok;
            if (chk_req && (addr_q == LastAddr)) begin
               state_d = ScanDraining;
            end
         end
         ScanDraining: begin
            if (fifo_pop && fifo_rdata[DW]) begin
               state_d = ScanDone;
            end
         end
         ScanDone, ScanInvalid: begin
            state_d = state_q;
         end
         default: begin
            state_illegal = 1'b1;
         end
      endcase
      fault = state_illegal | fifo_err_full | fifo_err_empty | cnt_mismatch;
      if (fault) begin
         state_d = ScanInvalid;
         chk_req = 1'b0;
      end
   end

   always_comb begin
      addr_d = addr_q;
      if (chk_req && (addr_q != LastAddr)) begin
         addr_d = addr_q + AW'(1);
      end
      req_d     = chk_req;
      last_d    = chk_req && (addr_q == LastAddr);
      alert_d   = alert_q | fault;
      // Once granted, the bus stays with the consumer until reset.
      sel_bus_d = (state_d == ScanDone) ? MuBi4True : sel_bus_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q    <= '0;
         req_q     <= 1'b0;
         last_q    <= 1'b0;
         alert_q   <= 1'b0;
         sel_bus_q <= MuBi4False;
      end else begin
         addr_q    <= addr_d;
         req_q     <= req_d;
         last_q    <= last_d;
         alert_q   <= alert_d;
         sel_bus_q <= sel_bus_d;
      end
   end

`ifdef ROM_CTRL_SCAN_CNT_CHECK_EN
   logic [AW-1:0] addr_dup_q, addr_dup_d;

   always_comb begin
      addr_dup_d = addr_dup_q;
      if (chk_req && (addr_dup_q != LastAddr)) begin
         addr_dup_d = addr_dup_q + AW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_dup_q <= '0;
      end else begin
         addr_dup_q <= addr_dup_d;
      end
   end

   assign cnt_mismatch = (addr_dup_q != addr_q);
`else
   assign cnt_mismatch = 1'b0;
`endif

   assign chk_req_o   = chk_req;
   assign chk_addr_o  = addr_q;
   assign data_o      = fifo_rdata[DW-1:0];
   assign data_last_o = data_valid_o & fifo_rdata[DW];
   assign sel_bus_o   = sel_bus_q;
   assign done_o      = (state_q == ScanDone);
   assign alert_o     = alert_q;

endmodule
`default_nettype wire
